apb_key_event: RTL

- APB3 slave peripheral that consumes the SoC's exported APB master bus: apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_prdata, apb_pready, apb_pslverr.
- Synchronises and debounces the board keys and turns press/release edges into events.
- Queues events in a small FIFO that firmware pops over APB; raises a level interrupt while events are pending.

---
 rtl/apb_key_event_pkg.sv | 47 ++++
 rtl/key_debounce.sv | 50 +++++
 rtl/apb_key_event.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/apb_key_event_pkg.sv
// Register map, bit positions and event record shared by the APB key event block.
// Pure definitions; no logic, no latency, no flow control.
// Optional timestamp field is populated only when APB_KEY_EVENT_TIMESTAMP_EN is defined.
package apb_key_event_pkg;

  localparam logic [11:0] ADDR_STATUS = 12'h000;
  localparam logic [11:0] ADDR_EVENT  = 12'h004;
  localparam logic [11:0] ADDR_KEYS   = 12'h008;
  localparam logic [11:0] ADDR_CTRL   = 12'h00C;
  localparam logic [11:0] ADDR_TSTAMP = 12'h010;

  localparam int STATUS_EMPTY   = 0;
  localparam int STATUS_FULL    = 1;
  localparam int STATUS_OVF     = 2;
  localparam int STATUS_CNT_LSB = 4;

  localparam int EVENT_KEY_LSB = 0;
  localparam int EVENT_PRESS   = 8;
  localparam int EVENT_VALID   = 9;
  localparam int EVENT_TS_LSB  = 16;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam int KEY_IDX_W = 4;
  localparam int TS_W      = 16;

  typedef struct packed {
    logic [TS_W-1:0]      tstamp;
    logic                 press;
    logic [KEY_IDX_W-1:0] key;
  } event_t;

  localparam int EVENT_W = $bits(event_t);

  function automatic logic [31:0] event_word(input event_t e);
    logic [31:0] w;
    w = '0;
    w[EVENT_KEY_LSB +: KEY_IDX_W] = e.key;
    w[EVENT_PRESS]                = e.press;
    w[EVENT_VALID]                = 1'b1;
    w[EVENT_TS_LSB +: TS_W]       = e.tstamp;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one key; level_o is 1 while pressed.
// Accepts a change after DEBOUNCE_CYCLES consecutive cycles of the new synced level.
// No backpressure: change_o is a single-cycle strobe the parent must capture.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic level_o,
  output logic change_o
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            INV     = (KEY_ACTIVE_LOW != 0);

  logic             sync_q0;
  logic             sync_q1;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pressed_raw;

  // Flops hold "pressed" polarity, so reset value 0 means released for either pin sense.
  assign pressed_raw = key_i ^ INV;
  assign change_o    = (sync_q1 != stable_q) && (cnt_q == CNT_MAX);
  assign level_o     = stable_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q0  <= 1'b0;
      sync_q1  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q0 <= pressed_raw;
      sync_q1 <= sync_q0;
      if (sync_q1 == stable_q) begin
        cnt_q <= '0;
      end else if (change_o) begin
        stable_q <= sync_q1;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_key_event.sv
// APB3 key event peripheral: debounced keys -> press/release events -> FIFO popped via EVENT reads.
// Zero-wait-state APB; events reach the FIFO 2 cycles after debounce acceptance, irq_o one cycle later.
// No backpressure on keys: a push into a full FIFO is dropped and sets sticky overflow. Macro: APB_KEY_EVENT_TIMESTAMP_EN.
module apb_key_event
  import apb_key_event_pkg::*;
#(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int FIFO_DEPTH      = 8,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [11:0]       apb_paddr,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic              apb_pready,
  output logic              apb_pslverr,
  input  logic [N_KEYS-1:0] key_i,
  output logic              irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [N_KEYS-1:0]    level;
  logic [N_KEYS-1:0]    change;
  logic [N_KEYS-1:0]    pending_q;
  logic [N_KEYS-1:0]    grant;
  logic [KEY_IDX_W-1:0] grant_idx;
  logic                 found;

  logic ctrl_en_q;
  logic irq_en_q;
  logic ovf_q;

  event_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     count_ext;
  logic            empty;
  logic            full;
  event_t          push_ev;

  logic access;
  logic rd_acc;
  logic wr_acc;
  logic sel_event;
  logic sel_ctrl;
  logic hit;
  logic pop;
  logic push_req;
  logic push;
  logic ovf_set;
  logic [31:0] rdata;
  logic unused_pwdata;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .key_i   (key_i[i]),
      .level_o (level[i]),
      .change_o(change[i])
    );
  end

`ifdef APB_KEY_EVENT_TIMESTAMP_EN
  localparam int               TICK_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DEBOUNCE_CYCLES - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic [TS_W-1:0]   ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      ts_q       <= '0;
    end else if (tick_cnt_q == TICK_MAX) begin
      tick_cnt_q <= '0;
      ts_q       <= ts_q + 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end
`endif

  // Fixed priority: lowest pending key index wins each cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (pending_q[i] && !found) begin
        grant[i]  = 1'b1;
        grant_idx = KEY_IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    push_ev       = '0;
    push_ev.key   = grant_idx;
    push_ev.press = |(level & grant);
`ifdef APB_KEY_EVENT_TIMESTAMP_EN
    push_ev.tstamp = ts_q;
`endif
  end

  assign access    = apb_psel & apb_penable;
  assign rd_acc    = access & ~apb_pwrite;
  assign wr_acc    = access & apb_pwrite;
  assign sel_event = (apb_paddr == ADDR_EVENT);
  assign sel_ctrl  = (apb_paddr == ADDR_CTRL);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign count_ext = 32'(count_q);

  assign pop      = rd_acc & sel_event & ~empty;
  assign push_req = ctrl_en_q & (|pending_q);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (apb_paddr)
      ADDR_STATUS: begin
        rdata[STATUS_EMPTY]          = empty;
        rdata[STATUS_FULL]           = full;
        rdata[STATUS_OVF]            = ovf_q;
        rdata[STATUS_CNT_LSB +: 4]   = count_ext[3:0];
      end
      ADDR_EVENT: begin
        if (!empty) rdata = event_word(mem[rd_ptr_q]);
      end
      ADDR_KEYS: rdata[N_KEYS-1:0] = level;
      ADDR_CTRL: begin
        rdata[CTRL_EN]     = ctrl_en_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
`ifdef APB_KEY_EVENT_TIMESTAMP_EN
      ADDR_TSTAMP: rdata[TS_W-1:0] = ts_q;
`endif
      default: hit = 1'b0;
    endcase
  end

  assign apb_prdata    = access ? rdata : '0;
  assign apb_pready    = access;
  assign apb_pslverr   = access & ~hit;
  assign unused_pwdata = ^apb_pwdata[31:3];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= push_ev;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ctrl_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      // Disabled: flags are discarded so nothing stale is pushed on re-enable.
      if (ctrl_en_q) pending_q <= (pending_q & ~grant) | change;
      else           pending_q <= '0;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);

      if (wr_acc && sel_ctrl) begin
        ctrl_en_q <= apb_pwdata[CTRL_EN];
        irq_en_q  <= apb_pwdata[CTRL_IRQ_EN];
        if (apb_pwdata[CTRL_OVF_CLR]) ovf_q <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;

      irq_o <= irq_en_q & (~empty | ovf_q);
    end
  end

endmodule
